conv_window_3x3: RTL

CONV_WINDOW_3X3 -- requirements
Module: conv_window_3x3

---
 rtl/conv_window_3x3_pkg.sv | 12 +
 rtl/conv_window_3x3_line_buf.sv | 25 ++
 rtl/conv_window_3x3.sv | 114 +++++++++++
 3 files changed

// File: rtl/conv_window_3x3_pkg.sv
// Shared defaults and helpers for the 3x3 sliding-window generator.
package conv_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IMG_W_DEF  = 28;
   localparam int IMG_H_DEF  = 28;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_window_3x3_line_buf.sv
// Single-port line buffer: combinational read of the old word, write of the new one at the clock edge.
module line_buf #(
   parameter int DEPTH  = 28,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic signed [DATA_W-1:0] rd_data
);

   logic signed [DATA_W-1:0] mem_q [DEPTH];

   assign rd_data = mem_q[addr];

   // Contents are intentionally never cleared; window gating hides stale rows.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/conv_window_3x3.sv
// Raster-scan 3x3 window generator: two line buffers feed a 3x3 shift register, one-cycle latency.
module conv_window_3x3
   import conv_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic signed [DATA_W-1:0] pix_in,
   input  logic                     pix_valid,
   input  logic                     pix_sof,
   output logic signed [DATA_W-1:0] win_1,
   output logic signed [DATA_W-1:0] win_2,
   output logic signed [DATA_W-1:0] win_3,
   output logic signed [DATA_W-1:0] win_4,
   output logic signed [DATA_W-1:0] win_5,
   output logic signed [DATA_W-1:0] win_6,
   output logic signed [DATA_W-1:0] win_7,
   output logic signed [DATA_W-1:0] win_8,
   output logic signed [DATA_W-1:0] win_9,
   output logic                     win_valid,
   output logic                     win_last
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);

   logic [COL_W-1:0]         col_q, col_d, col_cur;
   logic [ROW_W-1:0]         row_q, row_d, row_cur;
   logic                     accept;
   logic signed [DATA_W-1:0] lb1_rd, lb2_rd;
   logic signed [DATA_W-1:0] win_q [9];
   logic signed [DATA_W-1:0] win_d [9];
   logic                     win_valid_q, win_valid_d;
   logic                     win_last_q, win_last_d;

   // lb1 holds row r-1; lb2 holds row r-2 and is fed from lb1's outgoing word.
   line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb1 (
      .clk     (sys_clk),
      .we      (accept),
      .addr    (col_cur),
      .wr_data (pix_in),
      .rd_data (lb1_rd)
   );

   line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb2 (
      .clk     (sys_clk),
      .we      (accept),
      .addr    (col_cur),
      .wr_data (lb1_rd),
      .rd_data (lb2_rd)
   );

   always_comb begin
      accept      = pix_valid && !sys_rst;
      col_cur     = (pix_valid && pix_sof) ? '0 : col_q;
      row_cur     = (pix_valid && pix_sof) ? '0 : row_q;
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
      if (accept) begin
         if (col_cur == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_cur == ROW_W'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
         for (int i = 0; i < 3; i++) begin
            win_d[3*i]   = win_q[3*i+1];
            win_d[3*i+1] = win_q[3*i+2];
         end
         win_d[2] = lb2_rd;
         win_d[5] = lb1_rd;
         win_d[8] = pix_in;
         // c>=2 also masks the two columns whose left neighbours belong to the previous row.
         win_valid_d = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
         win_last_d  = (row_cur == ROW_W'(IMG_H - 1)) && (col_cur == COL_W'(IMG_W - 1));
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '{default: '0};
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
      end
   end

   assign win_1     = win_q[0];
   assign win_2     = win_q[1];
   assign win_3     = win_q[2];
   assign win_4     = win_q[3];
   assign win_5     = win_q[4];
   assign win_6     = win_q[5];
   assign win_7     = win_q[6];
   assign win_8     = win_q[7];
   assign win_9     = win_q[8];
   assign win_valid = win_valid_q;
   assign win_last  = win_last_q;

endmodule
